// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller driving an external PISO's load/shift strobes.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             load_bit,
  output logic             shift_bit,
  input  logic             piso_bit,
  output logic             tx_out,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          bit_end;

  assign bit_end   = (cnt == CNT_MAX);
  assign busy      = ~rst & (state != IDLE);
  assign tx_ready  = ~busy & ~rst;
  assign load_bit  = tx_valid & tx_ready;
  assign shift_bit = ~rst & (state == DATA) & bit_end & (idx != IDX_MAX);
  assign tx_done   = ~rst & (state == STOP) & bit_end;

`ifdef UART_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (load_bit) begin
      par <= ^tx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (load_bit) begin
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line is forced high during reset so an aborted frame never leaves it low
  always_comb begin
    tx_out = 1'b1;
    if (!rst) begin
      unique case (1'b1)
        (state == START): tx_out = 1'b0;
        (state == DATA):  tx_out = piso_bit;
`ifdef UART_TX_PARITY_EN
        (state == PARITY): tx_out = par;
`endif
        default: tx_out = 1'b1;
      endcase
    end
  end

endmodule
